// File: rtl/bcd_pkg.sv
`default_nettype none
// ============================================================================
// Module : bcd_pkg
// Shared constants, FSM encoding and digit check for the BCD-to-binary path.
// Rev    : 1.0  initial release
// ============================================================================
package bcd_pkg;

    localparam int         BCD_DIGITS = 4;
    localparam logic [3:0] BCD_MAX    = 4'd9;

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_CONV = 1'b1;

    function automatic logic bcd_valid(input logic [3:0] d);
        return (d <= BCD_MAX);
    endfunction

endpackage
`default_nettype wire

// File: rtl/bcd_to_bin_4digits_seq_if.sv
`default_nettype none
// ============================================================================
// Module : bcd_to_bin_4digits_seq_if
// Digit-entry / result handshake between a requester and the converter.
// Rev    : 1.0  initial release
// ============================================================================
interface bcd_to_bin_4digits_seq_if;

    logic        start;
    logic [3:0]  d0;
    logic [3:0]  d1;
    logic [3:0]  d2;
    logic [3:0]  d3;
    logic [15:0] value;
    logic        busy;
    logic        done;
    logic        err;

    modport master (
        output start, d0, d1, d2, d3,
        input  value, busy, done, err
    );

    modport slave (
        input  start, d0, d1, d2, d3,
        output value, busy, done, err
    );

endinterface
`default_nettype wire

// File: rtl/bcd_mac_step.sv
`default_nettype none
// ============================================================================
// Module : bcd_mac_step
// One multiply-by-10-accumulate step: acc*10 + digit, with invalid-digit fixup.
// Rev    : 1.0  initial release
// ============================================================================
module bcd_mac_step
    import bcd_pkg::*;
#(
    parameter bit CLAMP_INVALID = 1'b1
) (
    input  wire logic [15:0] i_acc,
    input  wire logic [3:0]  i_digit,
    output logic      [15:0] o_acc,
    output logic             o_invalid
);

    logic [3:0] w_dsel;

    always_comb begin
        o_invalid = !bcd_valid(i_digit);
        w_dsel    = i_digit;
        if (o_invalid) begin
            w_dsel = CLAMP_INVALID ? BCD_MAX : 4'd0;
        end
        // Shift-add form of *10 keeps this a pair of adders.
        o_acc = (i_acc << 3) + (i_acc << 1) + {12'd0, w_dsel};
    end

endmodule
`default_nettype wire

// File: rtl/bcd_to_bin_4digits_seq.sv
`default_nettype none
// ============================================================================
// Module : bcd_to_bin_4digits_seq
// Sequential 4-digit BCD-to-binary converter, one digit per clock.
// Rev    : 1.0  initial release
// ============================================================================
module bcd_to_bin_4digits_seq
    import bcd_pkg::*;
#(
    parameter bit CLAMP_INVALID = 1'b1
) (
    input wire logic                 clk,
    input wire logic                 rst,
    bcd_to_bin_4digits_seq_if.slave  bus
);

    logic [0:0]                  r_state;
    logic [0:0]                  w_state_nxt;
    logic [1:0]                  r_idx;
    logic [BCD_DIGITS-1:0][3:0]  r_dig;
    logic [15:0]                 r_acc;
    logic                        r_err_acc;
    logic [15:0]                 r_value;
    logic                        r_err;
    logic                        r_done;

    logic                        w_load;
    logic                        w_finish;
    logic                        w_busy;
    logic [15:0]                 w_mac_acc;
    logic                        w_mac_inv;

    bcd_mac_step #(
        .CLAMP_INVALID (CLAMP_INVALID)
    ) u_mac_step (
        .i_acc     (r_acc),
        .i_digit   (r_dig[r_idx]),
        .o_acc     (w_mac_acc),
        .o_invalid (w_mac_inv)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (bus.start)      w_state_nxt = S_CONV;
            S_CONV:  if (r_idx == 2'd3)  w_state_nxt = S_IDLE;
            default:                     w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        w_load   = (r_state == S_IDLE) && bus.start;
        w_finish = (r_state == S_CONV) && (r_idx == 2'd3);
        w_busy   = (r_state == S_CONV);
    end

    // Results move only on the completion edge so value/err are never partial.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_idx     <= 2'd0;
            r_dig     <= '0;
            r_acc     <= 16'd0;
            r_err_acc <= 1'b0;
            r_value   <= 16'd0;
            r_err     <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_done <= w_finish;
            if (w_load) begin
                r_dig     <= {bus.d3, bus.d2, bus.d1, bus.d0};
                r_acc     <= 16'd0;
                r_idx     <= 2'd0;
                r_err_acc <= 1'b0;
            end else if (r_state == S_CONV) begin
                r_acc     <= w_mac_acc;
                r_err_acc <= r_err_acc | w_mac_inv;
                r_idx     <= r_idx + 2'd1;
                if (w_finish) begin
                    r_value <= w_mac_acc;
                    r_err   <= r_err_acc | w_mac_inv;
                end
            end
        end
    end

    assign bus.value = r_value;
    assign bus.err   = r_err;
    assign bus.done  = r_done;
    assign bus.busy  = w_busy;

endmodule
`default_nettype wire

// File: tb/tb_bcd_to_bin_4digits_seq.sv
`default_nettype none
// ============================================================================
// Module : tb_bcd_to_bin_4digits_seq
// Directed and randomised checks of the sequential BCD-to-binary converter.
// Rev    : 1.0  initial release
// ============================================================================
module tb_bcd_to_bin_4digits_seq;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    bcd_to_bin_4digits_seq_if ifa ();
    bcd_to_bin_4digits_seq_if ifb ();

    bcd_to_bin_4digits_seq #(.CLAMP_INVALID(1'b1)) dut_a (.clk(clk), .rst(rst), .bus(ifa.slave));
    bcd_to_bin_4digits_seq #(.CLAMP_INVALID(1'b0)) dut_b (.clk(clk), .rst(rst), .bus(ifb.slave));

    int checks   = 0;
    int errors   = 0;
    int starts   = 0;
    int done_cnt = 0;

    always @(posedge clk) begin
        if (ifa.done === 1'b1) done_cnt <= done_cnt + 1;
    end

    task automatic set_in(input logic [3:0] a, b, c, d, input logic st);
        ifa.d0 = a; ifa.d1 = b; ifa.d2 = c; ifa.d3 = d; ifa.start = st;
        ifb.d0 = a; ifb.d1 = b; ifb.d2 = c; ifb.d3 = d; ifb.start = st;
    endtask

    // Runs one conversion from idle; lat = negedges after the start edge until done (-1 on timeout).
    task automatic conv(input logic [3:0] a, b, c, d,
                        output logic [15:0] va, output logic ea,
                        output logic [15:0] vb, output logic eb,
                        output int lat, output int bcnt);
        @(negedge clk); set_in(a, b, c, d, 1'b1); starts++;
        @(negedge clk); set_in(a, b, c, d, 1'b0);
        lat = -1; va = 'x; ea = 'x; vb = 'x; eb = 'x;
        bcnt = (ifa.busy === 1'b1) ? 1 : 0;
        for (int i = 1; i <= 16; i++) begin
            @(negedge clk);
            if (ifa.done === 1'b1) begin
                lat = i; va = ifa.value; ea = ifa.err; vb = ifb.value; eb = ifb.err;
                break;
            end
            if (ifa.busy === 1'b1) bcnt++;
        end
    endtask

    task automatic test_reset();
        set_in(0, 0, 0, 0, 1'b0);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (ifa.value !== 16'd0) begin errors++; $display("FAIL reset_value: got %0d want 0", ifa.value); end
        checks++; if (ifa.busy  !== 1'b0)  begin errors++; $display("FAIL reset_busy: got %b want 0", ifa.busy); end
        checks++; if (ifa.done  !== 1'b0)  begin errors++; $display("FAIL reset_done: got %b want 0", ifa.done); end
        checks++; if (ifa.err   !== 1'b0)  begin errors++; $display("FAIL reset_err: got %b want 0", ifa.err); end
        rst = 1'b0;
    endtask

    task automatic test_basic();
        logic [15:0] va, vb; logic ea, eb; int lat, bcnt;
        conv(1, 2, 3, 4, va, ea, vb, eb, lat, bcnt);
        checks++; if (lat !== 4)        begin errors++; $display("FAIL basic_latency: got %0d want 4", lat); end
        checks++; if (bcnt !== 4)       begin errors++; $display("FAIL basic_busy_cycles: got %0d want 4", bcnt); end
        checks++; if (va !== 16'd1234)  begin errors++; $display("FAIL basic_value: got %0d want 1234", va); end
        checks++; if (ea !== 1'b0)      begin errors++; $display("FAIL basic_err: got %b want 0", ea); end
        @(negedge clk);
        checks++; if (ifa.done !== 1'b0) begin errors++; $display("FAIL basic_done_pulse: got %b want 0", ifa.done); end
    endtask

    task automatic test_extremes();
        logic [15:0] va, vb; logic ea, eb; int lat, bcnt;
        conv(9, 9, 9, 9, va, ea, vb, eb, lat, bcnt);
        checks++; if (va !== 16'h270F) begin errors++; $display("FAIL max_value: got %h want 270f", va); end
        checks++; if (ea !== 1'b0)     begin errors++; $display("FAIL max_err: got %b want 0", ea); end
        conv(0, 0, 0, 0, va, ea, vb, eb, lat, bcnt);
        checks++; if (va !== 16'd0)    begin errors++; $display("FAIL zero_value: got %0d want 0", va); end
        checks++; if (ea !== 1'b0)     begin errors++; $display("FAIL zero_err: got %b want 0", ea); end
    endtask

    task automatic test_invalid();
        logic [15:0] va, vb; logic ea, eb; int lat, bcnt;
        conv(0, 0, 4'hC, 5, va, ea, vb, eb, lat, bcnt);
        checks++; if (va !== 16'd95) begin errors++; $display("FAIL clamp_value: got %0d want 95", va); end
        checks++; if (ea !== 1'b1)   begin errors++; $display("FAIL clamp_err: got %b want 1", ea); end
        checks++; if (vb !== 16'd5)  begin errors++; $display("FAIL zero_sub_value: got %0d want 5", vb); end
        checks++; if (eb !== 1'b1)   begin errors++; $display("FAIL zero_sub_err: got %b want 1", eb); end
    endtask

    task automatic test_back_to_back();
        int lat1 = -1, lat2 = -1;
        logic [15:0] v1 = 'x, v2 = 'x;
        @(negedge clk); set_in(0, 0, 4, 2, 1'b1); starts++;
        @(negedge clk); set_in(0, 0, 4, 2, 1'b0);
        for (int i = 1; i <= 16; i++) begin
            @(negedge clk);
            if (ifa.done === 1'b1) begin lat1 = i; v1 = ifa.value; break; end
        end
        set_in(0, 0, 0, 7, 1'b1); starts++;
        @(negedge clk); set_in(0, 0, 0, 7, 1'b0);
        checks++; if (ifa.busy !== 1'b1) begin errors++; $display("FAIL b2b_busy_rise: got %b want 1", ifa.busy); end
        for (int i = 1; i <= 16; i++) begin
            @(negedge clk);
            if (ifa.done === 1'b1) begin lat2 = i; v2 = ifa.value; break; end
        end
        checks++; if (lat1 !== 4)     begin errors++; $display("FAIL b2b_first_latency: got %0d want 4", lat1); end
        checks++; if (v1 !== 16'd42)  begin errors++; $display("FAIL b2b_first_value: got %0d want 42", v1); end
        checks++; if (lat2 !== 4)     begin errors++; $display("FAIL b2b_second_latency: got %0d want 4", lat2); end
        checks++; if (v2 !== 16'd7)   begin errors++; $display("FAIL b2b_second_value: got %0d want 7", v2); end
    endtask

    task automatic test_ignored_start();
        int n = 0;
        logic [15:0] v = 'x;
        @(negedge clk); set_in(5, 0, 0, 1, 1'b1); starts++;
        @(negedge clk); set_in(5, 0, 0, 1, 1'b0);
        @(negedge clk); set_in(9, 9, 9, 9, 1'b1);
        @(negedge clk); set_in(9, 9, 9, 9, 1'b0);
        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            if (ifa.done === 1'b1) begin n++; v = ifa.value; end
        end
        checks++; if (n !== 1)        begin errors++; $display("FAIL ignored_start_dones: got %0d want 1", n); end
        checks++; if (v !== 16'd5001) begin errors++; $display("FAIL captured_digits_value: got %0d want 5001", v); end
    endtask

    task automatic test_reset_mid();
        int n = 0;
        logic [15:0] va, vb; logic ea, eb; int lat, bcnt;
        @(negedge clk); set_in(5, 6, 7, 8, 1'b1);
        @(negedge clk); set_in(5, 6, 7, 8, 1'b0);
        @(negedge clk); rst = 1'b1;
        @(negedge clk);
        checks++; if (ifa.value !== 16'd0) begin errors++; $display("FAIL midreset_value: got %0d want 0", ifa.value); end
        checks++; if (ifa.busy  !== 1'b0)  begin errors++; $display("FAIL midreset_busy: got %b want 0", ifa.busy); end
        checks++; if (ifa.err   !== 1'b0)  begin errors++; $display("FAIL midreset_err: got %b want 0", ifa.err); end
        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (ifa.done === 1'b1) n++;
        end
        checks++; if (n !== 0) begin errors++; $display("FAIL midreset_no_done: got %0d want 0", n); end
        conv(5, 6, 7, 8, va, ea, vb, eb, lat, bcnt);
        checks++; if (va !== 16'd5678) begin errors++; $display("FAIL after_reset_value: got %0d want 5678", va); end
        checks++; if (ea !== 1'b0)     begin errors++; $display("FAIL after_reset_err: got %b want 0", ea); end
    endtask

    task automatic test_random();
        logic [15:0] va, vb; logic ea, eb; int lat, bcnt;
        int v;
        logic [3:0] a, b, c, d;
        for (int r = 0; r < 1000; r++) begin
            v = int'($urandom_range(0, 9999));
            a = 4'(v / 1000); b = 4'((v / 100) % 10); c = 4'((v / 10) % 10); d = 4'(v % 10);
            conv(a, b, c, d, va, ea, vb, eb, lat, bcnt);
            checks++; if (va !== 16'(v)) begin errors++; $display("FAIL random_value: got %0d want %0d", va, v); end
            checks++; if (ea !== 1'b0)   begin errors++; $display("FAIL random_err: got %b want 0 (value %0d)", ea, v); end
            checks++; if (vb !== 16'(v)) begin errors++; $display("FAIL random_value_b: got %0d want %0d", vb, v); end
        end
        repeat (2) @(negedge clk);
        checks++; if (done_cnt !== starts) begin errors++; $display("FAIL done_count: got %0d want %0d", done_cnt, starts); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_extremes();
        test_invalid();
        test_back_to_back();
        test_ignored_start();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
